// File: rtl/input_conditioner.sv
// input_conditioner
// Debounces the synchronized Next/Done buttons, converts clean presses into
// single-cycle pulses, captures the switch word with each LOAD-phase Next
// pulse and tracks the bounded load phase (count, full, overflow).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_LOAD | accepting words; Next captures data, Done moves to ST_RUN
// ST_RUN  | Next is a step command only; Done ignored; left by reset only
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int MAX_WORDS       = 64,
    parameter int DATA_W          = 6,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES),
    localparam int WC_W           = $clog2(MAX_WORDS + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              next_raw,
    input  logic              done_raw,
    input  logic [DATA_W-1:0] data_raw,
    output logic              next_pulse,
    output logic              done_pulse,
    output logic [DATA_W-1:0] data_out,
    output logic [WC_W-1:0]   word_count,
    output logic              load_full,
    output logic              overflow,
    output logic              running
);

    // Counter value on which a still-differing sample flips the level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(MAX_WORDS);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t            r_state;
    logic              r_next_lvl, r_next_lvl_d;
    logic              r_done_lvl, r_done_lvl_d;
    logic [CNT_W-1:0]  r_next_cnt, r_done_cnt;
    logic              r_next_pulse, r_done_pulse;
    logic [DATA_W-1:0] r_data;
    logic [WC_W-1:0]   r_word_count;
    logic              r_overflow;
    logic              r_running;

    logic              w_next_evt;
    logic              w_done_evt;

    // Next debouncer: count consecutive mismatching samples, flip when enough.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_next_lvl <= 1'b0;
            r_next_cnt <= '0;
        end else if (next_raw == r_next_lvl) begin
            r_next_cnt <= '0;
        end else if (r_next_cnt == CNT_LAST) begin
            r_next_lvl <= next_raw;
            r_next_cnt <= '0;
        end else begin
            r_next_cnt <= r_next_cnt + CNT_W'(1);
        end
    end

    // Done debouncer: identical behaviour to the Next debouncer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_done_lvl <= 1'b0;
            r_done_cnt <= '0;
        end else if (done_raw == r_done_lvl) begin
            r_done_cnt <= '0;
        end else if (r_done_cnt == CNT_LAST) begin
            r_done_lvl <= done_raw;
            r_done_cnt <= '0;
        end else begin
            r_done_cnt <= r_done_cnt + CNT_W'(1);
        end
    end

    // Delayed copies of the debounced levels for rising-edge (press) detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_next_lvl_d <= 1'b0;
            r_done_lvl_d <= 1'b0;
        end else begin
            r_next_lvl_d <= r_next_lvl;
            r_done_lvl_d <= r_done_lvl;
        end
    end

    // Presses only; releases never generate events.
    assign w_next_evt = r_next_lvl & ~r_next_lvl_d;
    assign w_done_evt = r_done_lvl & ~r_done_lvl_d;

    // LOAD/RUN controller with registered pulses, capture and load tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_LOAD;
            r_next_pulse <= 1'b0;
            r_done_pulse <= 1'b0;
            r_data       <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            r_next_pulse <= 1'b0;
            r_done_pulse <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    // Next is resolved before Done so a simultaneous press
                    // still loads its word before the phase closes.
                    if (w_next_evt) begin
                        if (r_word_count < WC_MAX) begin
                            r_next_pulse <= 1'b1;
                            r_data       <= data_raw;
                            r_word_count <= r_word_count + WC_W'(1);
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                    if (w_done_evt) begin
                        r_done_pulse <= 1'b1;
                        r_running    <= 1'b1;
                        r_state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_next_evt) begin
                        r_next_pulse <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign next_pulse = r_next_pulse;
    assign done_pulse = r_done_pulse;
    assign data_out   = r_data;
    assign word_count = r_word_count;
    assign load_full  = (r_word_count == WC_MAX);
    assign overflow   = r_overflow;
    assign running    = r_running;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus randomized button
// activity, every cycle checked against a sample-history reference model.
module tb_input_conditioner;

    localparam int D    = 4;
    localparam int MAXW = 4;
    localparam int DW   = 6;
    localparam int WCW  = $clog2(MAXW + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          next_raw = 1'b0;
    logic          done_raw = 1'b0;
    logic [DW-1:0] data_raw = '0;
    logic          next_pulse, done_pulse;
    logic [DW-1:0] data_out;
    logic [WCW-1:0] word_count;
    logic          load_full, overflow, running;

    input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .MAX_WORDS      (MAXW),
        .DATA_W         (DW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .next_raw  (next_raw),
        .done_raw  (done_raw),
        .data_raw  (data_raw),
        .next_pulse(next_pulse),
        .done_pulse(done_pulse),
        .data_out  (data_out),
        .word_count(word_count),
        .load_full (load_full),
        .overflow  (overflow),
        .running   (running)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int n_next_seen = 0;
    int n_done_seen = 0;

    // Reference model state.
    logic     hist_n[$];
    logic     hist_d[$];
    logic     lvl_n = 1'b0, lvl_d = 1'b0;
    bit       pend_n = 0, pend_d = 0;
    bit       e_next = 0, e_done = 0, e_ovf = 0, e_run = 0;
    int       e_wc = 0;
    int       e_data = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // True when the most recent D-1 samples all disagree with the level.
    function automatic bit streak(input logic q[$], input logic lvl);
        if (q.size() < D - 1) return 1'b0;
        for (int i = q.size() - (D - 1); i < q.size(); i++)
            if (q[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        if (reset) begin
            hist_n.delete(); hist_d.delete();
            lvl_n = 0; lvl_d = 0; pend_n = 0; pend_d = 0;
            e_next = 0; e_done = 0; e_ovf = 0; e_run = 0; e_wc = 0; e_data = 0;
            return;
        end
        e_next = 0;
        e_done = 0;
        if (pend_n) begin
            if (e_run) e_next = 1;
            else if (e_wc < MAXW) begin
                e_next = 1; e_data = int'(data_raw); e_wc++;
            end else e_ovf = 1;
        end
        if (pend_d && !e_run) begin
            e_done = 1; e_run = 1;
        end
        pend_n = 0;
        pend_d = 0;
        hist_n.push_back(next_raw);
        if (hist_n.size() > D) void'(hist_n.pop_front());
        if (streak(hist_n, lvl_n)) begin
            lvl_n = next_raw; hist_n.delete();
            if (lvl_n) pend_n = 1;
        end
        hist_d.push_back(done_raw);
        if (hist_d.size() > D) void'(hist_d.pop_front());
        if (streak(hist_d, lvl_d)) begin
            lvl_d = done_raw; hist_d.delete();
            if (lvl_d) pend_d = 1;
        end
    endtask

    task automatic check_all();
        chk("next_pulse", int'(next_pulse), int'(e_next));
        chk("done_pulse", int'(done_pulse), int'(e_done));
        chk("data_out",   int'(data_out),   e_data);
        chk("word_count", int'(word_count), e_wc);
        chk("load_full",  int'(load_full),  int'(e_wc == MAXW));
        chk("overflow",   int'(overflow),   int'(e_ovf));
        chk("running",    int'(running),    int'(e_run));
        if (next_pulse) n_next_seen++;
        if (done_pulse) n_done_seen++;
    endtask

    task automatic tick(input logic r, input logic n, input logic d, input logic [DW-1:0] w);
        reset = r; next_raw = n; done_raw = d; data_raw = w;
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    // Clean press: held high, then released long enough to debounce both edges.
    task automatic press(input logic n, input logic d, input logic [DW-1:0] w);
        for (int i = 0; i < 6; i++) tick(0, n, d, w);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, w);
    endtask

    initial begin
        int first_idx;
        int base_n, base_d;
        logic [DW-1:0] last_word;
        logic [DW-1:0] w;
        int hold_n, hold_d;
        logic rn, rd;

        // Reset with Next held: outputs clear, one fresh press after release.
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 6'h00);
        chk("rst_running", int'(running), 0);
        chk("rst_wc", int'(word_count), 0);
        first_idx = -1;
        base_n = n_next_seen;
        for (int i = 1; i <= 10; i++) begin
            tick(0, 1, 0, 6'h00);
            if (next_pulse && first_idx < 0) first_idx = i;
        end
        chk("rst_latency", first_idx, D);
        chk("rst_pulses", n_next_seen - base_n, 1);

        // Bounce: 1,0,1,1,0 then hold 1 -> single pulse.
        tick(1, 0, 0, 6'h00);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 6'h00);
        base_n = n_next_seen;
        tick(0, 1, 0, 6'h00); tick(0, 0, 0, 6'h00); tick(0, 1, 0, 6'h00);
        tick(0, 1, 0, 6'h00); tick(0, 0, 0, 6'h00);
        first_idx = -1;
        for (int i = 1; i <= 10; i++) begin
            tick(0, 1, 0, 6'h00);
            if (next_pulse && first_idx < 0) first_idx = i;
        end
        chk("bounce_latency", first_idx, D);
        chk("bounce_pulses", n_next_seen - base_n, 1);
        chk("bounce_wc", int'(word_count), 1);

        // Capture two words.
        tick(1, 0, 0, 6'h00);
        press(1, 0, 6'h2A);
        chk("cap1_data", int'(data_out), 'h2A);
        press(1, 0, 6'h15);
        chk("cap2_data", int'(data_out), 'h15);
        chk("cap_wc", int'(word_count), 2);

        // Fill beyond MAX_WORDS.
        tick(1, 0, 0, 6'h00);
        base_n = n_next_seen;
        last_word = '0;
        for (int i = 0; i < 5; i++) begin
            w = DW'($urandom);
            if (i == 3) last_word = w;
            press(1, 0, w);
            if (i == 3) chk("full_pre_ovf", int'(overflow), 0);
        end
        chk("full_pulses", n_next_seen - base_n, MAXW);
        chk("full_wc", int'(word_count), MAXW);
        chk("full_flag", int'(load_full), 1);
        chk("full_ovf", int'(overflow), 1);
        chk("full_data", int'(data_out), int'(last_word));

        // Transition: two words, simultaneous Next+Done, then RUN behaviour.
        tick(1, 0, 0, 6'h00);
        base_n = n_next_seen;
        base_d = n_done_seen;
        press(1, 0, 6'h01);
        press(1, 0, 6'h02);
        press(1, 1, 6'h03);
        chk("tr_running", int'(running), 1);
        chk("tr_wc", int'(word_count), 3);
        chk("tr_data", int'(data_out), 'h03);
        chk("tr_done_cnt", n_done_seen - base_d, 1);
        press(0, 1, 6'h3F);
        chk("run_done_ignored", n_done_seen - base_d, 1);
        press(1, 0, 6'h3F);
        chk("run_next_cnt", n_next_seen - base_n, 4);
        chk("run_wc_held", int'(word_count), 3);
        chk("run_data_held", int'(data_out), 'h03);

        // Reset in RUN, then loading resumes.
        tick(1, 0, 0, 6'h00);
        chk("rr_running", int'(running), 0);
        chk("rr_wc", int'(word_count), 0);
        chk("rr_ovf", int'(overflow), 0);
        press(1, 0, 6'h0C);
        chk("rr_reload_wc", int'(word_count), 1);
        chk("rr_reload_data", int'(data_out), 'h0C);

        // Randomized button activity with occasional resets.
        hold_n = 0; hold_d = 0; rn = 0; rd = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold_n == 0) begin rn = ~rn; hold_n = $urandom_range(1, 9); end
            if (hold_d == 0) begin
                rd = ~rd;
                hold_d = rd ? $urandom_range(1, 6) : $urandom_range(1, 60);
            end
            hold_n--; hold_d--;
            tick(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0, rn, rd, DW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
